// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_pkg                                                        |
// | Shared constants and state encoding for the IMEM boot loader.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imem_boot_pkg;

   localparam int MEM_NBYTE_DEF = 4096;
   localparam int WORD_BYTES    = 4;
   localparam int BIDX_W        = $clog2(WORD_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_WORD = 2'd1,
      ST_WRITE     = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_word_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_byte_serializer                                                 |
// | Loads a 32-bit word and emits its bytes LSB first, one per cycle.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module word_byte_serializer
   import imem_boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [31:0]       word,
   output logic [7:0]        wbyte,
   output logic [BIDX_W-1:0] bidx,
   output logic              active,
   output logic              last
);

   localparam logic [BIDX_W-1:0] c_last_idx = BIDX_W'(WORD_BYTES - 1);
   localparam logic [BIDX_W-1:0] c_one      = BIDX_W'(1);

   logic [31:0]       r_shift;
   logic [BIDX_W-1:0] r_bidx;
   logic              r_active;

   // Bytes stream out back to back; there is no stall once a word is loaded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift  <= '0;
         r_bidx   <= '0;
         r_active <= 1'b0;
      end else if (load) begin
         r_shift  <= word;
         r_bidx   <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_shift <= {8'h00, r_shift[31:8]};
         r_bidx  <= r_bidx + c_one;
         if (r_bidx == c_last_idx) begin
            r_active <= 1'b0;
         end
      end
   end

   assign wbyte  = r_shift[7:0];
   assign bidx   = r_bidx;
   assign active = r_active;
   assign last   = r_active && (r_bidx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_loader                                                     |
// | Streams instruction words into byte-wide IMEM, holds core in reset.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int          MEM_NBYTE = MEM_NBYTE_DEF,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NW_W      = $clog2(MEM_NBYTE / 4) + 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [NW_W-1:0] nwords,
   input  logic            s_valid,
   input  logic [31:0]     s_data,
   output logic            s_ready,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [7:0]      mem_wdata,
   output logic            cpu_rst_n,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [NW_W-1:0] c_max_words = NW_W'(MEM_NBYTE / WORD_BYTES);
   localparam logic [NW_W-1:0] c_one       = NW_W'(1);
   localparam int              c_wa_w      = 32 - BIDX_W;

   state_t            r_state;
   state_t            w_state_next;
   logic [NW_W-1:0]   r_nwords;
   logic [NW_W-1:0]   r_widx;
   logic [c_wa_w-1:0] r_wbase;
   logic              r_err;

   logic              w_accept;
   logic              w_start_ok;
   logic              w_start_bad;
   logic              w_next_word;
   logic              w_ser_last;
   logic              w_ser_active;
   logic [BIDX_W-1:0] w_bidx;
   logic [7:0]        w_byte;

   assign w_accept = s_valid && (r_state == ST_WAIT_WORD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start_ok   = 1'b0;
      w_start_bad  = 1'b0;
      w_next_word  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if ((nwords == '0) || (nwords > c_max_words)) begin
                  w_start_bad  = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_start_ok   = 1'b1;
                  w_state_next = ST_WAIT_WORD;
               end
            end
         end
         ST_WAIT_WORD: begin
            if (s_valid) begin
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (w_ser_last) begin
               if (r_widx == (r_nwords - c_one)) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_next_word  = 1'b1;
                  w_state_next = ST_WAIT_WORD;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Word base is latched at acceptance so the byte index forms the low address bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_nwords <= '0;
         r_widx   <= '0;
         r_wbase  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_nwords <= nwords;
            r_widx   <= '0;
            r_err    <= 1'b0;
         end else if (w_start_bad) begin
            r_err    <= 1'b1;
         end
         if (w_next_word) begin
            r_widx <= r_widx + c_one;
         end
         if (w_accept) begin
            r_wbase <= BASE_ADDR[31:BIDX_W] + c_wa_w'(r_widx);
         end
      end
   end

   word_byte_serializer u_ser (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_accept),
      .word   (s_data),
      .wbyte  (w_byte),
      .bidx   (w_bidx),
      .active (w_ser_active),
      .last   (w_ser_last)
   );

   assign s_ready   = (r_state == ST_WAIT_WORD);
   assign busy      = (r_state == ST_WAIT_WORD) || (r_state == ST_WRITE);
   assign done      = (r_state == ST_DONE);
   assign cpu_rst_n = (r_state == ST_DONE);
   assign err       = r_err;
   assign mem_we    = w_ser_active;
   assign mem_addr  = {r_wbase, w_bidx};
   assign mem_wdata = w_byte;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_boot_loader                                                  |
// | Directed bench for the IMEM boot loader with a byte-wide IMEM model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imem_boot_loader;

   localparam int NW_W = 11;

   logic            clk     = 1'b0;
   logic            rst_n   = 1'b0;
   logic            start   = 1'b0;
   logic [NW_W-1:0] nwords  = '0;
   logic            s_valid = 1'b0;
   logic [31:0]     s_data  = '0;
   logic            s_ready;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [7:0]      mem_wdata;
   logic            cpu_rst_n;
   logic            busy;
   logic            done;
   logic            err;

   int          checks    = 0;
   int          errors    = 0;
   int          wr_cnt    = 0;
   int          bad_we    = 0;
   logic [31:0] max_addr  = '0;
   logic [31:0] last_addr = '0;
   logic [7:0]  mem [0:4095];

   always #5 clk = ~clk;

   imem_boot_loader #(
      .MEM_NBYTE (4096),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .nwords    (nwords),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // IMEM write port model
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         wr_cnt    <= wr_cnt + 1;
         last_addr <= mem_addr;
         if (mem_addr > max_addr) max_addr <= mem_addr;
         if (mem_addr < 32'd4096) mem[mem_addr[11:0]] <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if ((mem_we === 1'b1) && (s_ready || done || !busy || cpu_rst_n))
         bad_we <= bad_we + 1;
   end

   function automatic logic [31:0] imem_rd(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int n);
      start  = 1'b1;
      nwords = NW_W'(n);
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Returns on the negedge right after the acceptance edge (first byte write visible).
   task automatic feed(input logic [31:0] d);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_data  = d;
      while ((s_ready !== 1'b1) && (n < 20)) begin
         @(negedge clk);
         n++;
      end
      chk("feed_timeout", 32'(n < 20), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("we_b%0d", b),    32'(mem_we),    32'd1);
         chk($sformatf("addr_b%0d", b),  mem_addr,       a + 32'(b));
         chk($sformatf("wdata_b%0d", b), 32'(mem_wdata), 32'(d[8*b +: 8]));
         chk($sformatf("rdy_b%0d", b),   32'(s_ready),   32'd0);
         chk($sformatf("crst_b%0d", b),  32'(cpu_rst_n), 32'd0);
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"},   32'(s_ready),   32'd0);
      chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
      chk({tag, "_mem_addr"},  mem_addr,       32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_err"},       32'(err),       32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // two-word load
      do_start(2);
      chk("t1_busy",  32'(busy),    32'd1);
      chk("t1_ready", 32'(s_ready), 32'd1);
      feed(32'h0000_0093);
      expect_word(32'd0, 32'h0000_0093);
      chk("t1_mid_ready", 32'(s_ready), 32'd1);
      chk("t1_mid_done",  32'(done),    32'd0);
      feed(32'h0050_0113);
      expect_word(32'd4, 32'h0050_0113);
      chk("t1_we_off", 32'(mem_we),    32'd0);
      chk("t1_crst",   32'(cpu_rst_n), 32'd1);
      chk("t1_done",   32'(done),      32'd1);
      chk("t1_busy0",  32'(busy),      32'd0);
      chk("t1_wrcnt",  32'(wr_cnt),    32'd8);
      chk("t1_rd0",    imem_rd(0),     32'h0000_0093);
      chk("t1_rd4",    imem_rd(4),     32'h0050_0113);

      // continuous s_valid: one acceptance per 5 cycles
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      do_start(3);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("t2_ready_c%0d", i), 32'(s_ready), 32'((i % 5) == 0));
         chk($sformatf("t2_we_c%0d", i),    32'(mem_we),  32'((i % 5) != 0));
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("t2_done",  32'(done),   32'd1);
      chk("t2_wrcnt", 32'(wr_cnt), 32'd20);

      // rejected starts
      do_start(0);
      chk("t3_err0",  32'(err),       32'd1);
      chk("t3_done0", 32'(done),      32'd0);
      chk("t3_crst0", 32'(cpu_rst_n), 32'd0);
      chk("t3_busy0", 32'(busy),      32'd0);
      do_start(1025);
      chk("t3_err1",  32'(err),       32'd1);
      chk("t3_busy1", 32'(busy),      32'd0);
      repeat (2) @(negedge clk);
      chk("t3_crst1", 32'(cpu_rst_n), 32'd0);
      chk("t3_nowr",  32'(wr_cnt),    32'd20);
      do_start(1);
      chk("t3_errclr", 32'(err),  32'd0);
      chk("t3_busy2",  32'(busy), 32'd1);
      feed(32'h1122_3344);
      expect_word(32'd0, 32'h1122_3344);
      chk("t3_done2", 32'(done),      32'd1);
      chk("t3_crst2", 32'(cpu_rst_n), 32'd1);

      // reset during the second of three words
      do_start(3);
      feed(32'hA1A2_A3A4);
      expect_word(32'd0, 32'hA1A2_A3A4);
      feed(32'hB1B2_B3B4);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("t4");
      rst_n   = 1'b1;
      s_valid = 1'b1;
      repeat (10) @(negedge clk);
      s_valid = 1'b0;
      chk("t4_wrcnt", 32'(wr_cnt),    32'd29);
      chk("t4_crst",  32'(cpu_rst_n), 32'd0);
      chk("t4_ready", 32'(s_ready),   32'd0);

      // start while busy is ignored, then reload from DONE
      do_start(2);
      feed(32'hC0FF_EE01);
      start  = 1'b1;
      nwords = NW_W'(1);
      @(negedge clk);
      start  = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_ready", 32'(s_ready), 32'd1);
      chk("t5_done",  32'(done),    32'd0);
      chk("t5_busy",  32'(busy),    32'd1);
      feed(32'hC0FF_EE02);
      repeat (4) @(negedge clk);
      chk("t5_done1", 32'(done),      32'd1);
      chk("t5_crst1", 32'(cpu_rst_n), 32'd1);
      chk("t5_rd4",   imem_rd(4),     32'hC0FF_EE02);
      do_start(1);
      chk("t5_crst_drop", 32'(cpu_rst_n), 32'd0);
      chk("t5_done_drop", 32'(done),      32'd0);
      feed(32'h0BAD_F00D);
      expect_word(32'd0, 32'h0BAD_F00D);
      chk("t5_crst2", 32'(cpu_rst_n), 32'd1);
      chk("t5_rd0",   imem_rd(0),     32'h0BAD_F00D);

      // full memory
      do_start(1024);
      for (int i = 0; i < 1024; i++) begin
         feed(32'hA500_0000 | 32'(i));
      end
      repeat (4) @(negedge clk);
      chk("t6_done",     32'(done),      32'd1);
      chk("t6_crst",     32'(cpu_rst_n), 32'd1);
      chk("t6_lastaddr", last_addr,      32'd4095);
      chk("t6_maxaddr",  max_addr,       32'd4095);
      chk("t6_rd0",      imem_rd(0),     32'hA500_0000);
      chk("t6_rdlast",   imem_rd(4092),  32'hA500_03FF);
      chk("we_outside_write", 32'(bad_we), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
